// File: rtl/sha_digest_checker_if.sv
// sha_digest_checker_if: expected-word load, digest capture and result bus of sha_digest_checker
interface sha_digest_checker_if #(
  parameter int WORD_W = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int ADDR_W = 3
);
  logic we;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic clear;
  logic [WORD_W*DIGEST_WORDS-1:0] digest_in;
  logic digest_in_valid;
  logic [DIGEST_WORDS-1:0] words_loaded;
  logic busy;
  logic done;
  logic match;
  logic mismatch;
  logic locked;
  modport master (
    output we, address, write_data, clear, digest_in, digest_in_valid,
    input words_loaded, busy, done, match, mismatch, locked
  );
  modport slave (
    input we, address, write_data, clear, digest_in, digest_in_valid,
    output words_loaded, busy, done, match, mismatch, locked
  );
endinterface

// File: rtl/sha_digest_checker.sv
// sha_digest_checker: constant-time expected-vs-computed digest compare; SHA_CHECK_LOCKOUT_EN adds a fail-count lockout
module sha_digest_checker #(
  parameter int WORD_W = 32,
  parameter int DIGEST_WORDS = 8,
  parameter int ADDR_W = 3,
  parameter int MAX_FAILS = 3
) (
  input logic clk,
  input logic rst,
  sha_digest_checker_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  if (DIGEST_WORDS < 1 || DIGEST_WORDS > 16 || (2 ** ADDR_W) < DIGEST_WORDS ||
      MAX_FAILS < 1 || MAX_FAILS > 255) begin : g_bad_params
    $error("sha_digest_checker: illegal parameter set");
  end
`ifdef SHA_CHECK_LOCKOUT_EN
  typedef enum logic [1:0] {LOAD, COMPARE, RESULT, LOCKED} state_t;
`else
  typedef enum logic [1:0] {LOAD, COMPARE, RESULT} state_t;
`endif
  state_t state;
  logic [WORD_W-1:0] words [DIGEST_WORDS];
  logic [WORD_W*DIGEST_WORDS-1:0] snap;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] diff;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [DIGEST_WORDS-1:0] loaded;
  logic captured, busy, done, match, mismatch, locked, frozen, wr_ok;
  assign idx = cnt[ADDR_W-1:0];
  assign diff = words[idx] ^ snap[idx*WORD_W +: WORD_W];
  assign wr_ok = bus.we && 32'(bus.address) < DIGEST_WORDS;
`ifdef SHA_CHECK_LOCKOUT_EN
  logic [7:0] fails;
  logic last_fail;
  assign frozen = state == LOCKED;
  assign last_fail = 32'(fails) + 1 >= MAX_FAILS;
`else
  assign frozen = 1'b0;
  assign locked = 1'b0;
`endif
  // The extra cycle at cnt == DIGEST_WORDS turns the finished accumulator into a verdict,
  // so a result always costs the same number of cycles whatever the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      loaded <= '0;
      captured <= 1'b0;
      snap <= '0;
      acc <= '0;
      cnt <= '0;
      {busy, done, match, mismatch} <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) words[i] <= '0;
`ifdef SHA_CHECK_LOCKOUT_EN
      fails <= '0;
      locked <= 1'b0;
`endif
    end else if (bus.clear && !frozen) begin
      state <= LOAD;
      loaded <= '0;
      captured <= 1'b0;
      acc <= '0;
      cnt <= '0;
      {busy, done, match, mismatch} <= '0;
    end else if (state == LOAD) begin
      if (wr_ok) begin
        words[bus.address] <= bus.write_data;
        loaded[bus.address] <= 1'b1;
      end
      if (bus.digest_in_valid) begin
        snap <= bus.digest_in;
        captured <= 1'b1;
      end
      if (&loaded && captured) begin
        state <= COMPARE;
        busy <= 1'b1;
      end
    end else if (state == COMPARE) begin
      if (32'(cnt) < DIGEST_WORDS) begin
        acc <= acc | diff;
        cnt <= cnt + 1'b1;
      end else begin
        state <= RESULT;
        busy <= 1'b0;
        done <= 1'b1;
        match <= ~|acc;
        mismatch <= |acc;
`ifdef SHA_CHECK_LOCKOUT_EN
        if (|acc) fails <= fails + 1'b1;
        if (|acc && last_fail) begin
          state <= LOCKED;
          locked <= 1'b1;
        end
`endif
      end
    end
  end
  assign bus.words_loaded = loaded;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.match = match;
  assign bus.mismatch = mismatch;
  assign bus.locked = locked;
endmodule

// File: doc/sha_digest_checker.md
SHA_DIGEST_CHECKER -- requirements
Module: sha_digest_checker

Interface
REQ-001 SHALL have parameter WORD_W, default 32, bit width of one digest word.
REQ-002 SHALL have parameter DIGEST_WORDS, default 8, number of words per digest; legal range is 1..16.
REQ-003 SHALL have parameter ADDR_W, default 3, word-address width; 2**ADDR_W >= DIGEST_WORDS.
REQ-004 SHALL have parameter MAX_FAILS, default 3, mismatch count that triggers lockout; legal range is 1..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every register is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port we, input, 1 bit: writes the expected-digest word selected by address.
REQ-008 SHALL have port address, input, ADDR_W bits: expected-word index.
REQ-009 SHALL have port write_data, input, WORD_W bits: expected-word value.
REQ-010 SHALL have port clear, input, 1 bit: aborts the current check and starts a new one.
REQ-011 SHALL have port digest_in, input, WORD_W*DIGEST_WORDS bits: computed digest from the SHA core; word i occupies bits [i*WORD_W +: WORD_W].
REQ-012 SHALL have port digest_in_valid, input, 1 bit: digest_in is valid in this cycle.
REQ-013 SHALL have port words_loaded, output, DIGEST_WORDS bits: bitmap of expected words written so far.
REQ-014 SHALL have outputs busy, done, match and mismatch, each 1 bit: compare running, result held, digests equal, digests differ.
REQ-015 SHALL have output locked, 1 bit: lockout is active.

Function
REQ-016 SHALL implement an FSM with states LOAD, COMPARE, RESULT and LOCKED.
REQ-017 In LOAD, a write with we=1 and address<DIGEST_WORDS SHALL store write_data into word[address] and set words_loaded[address].
REQ-018 A write to a word that is already loaded SHALL overwrite the stored value; its words_loaded bit stays 1.
REQ-019 A write with address>=DIGEST_WORDS SHALL be ignored.
REQ-020 Writes in any state other than LOAD SHALL be ignored.
REQ-021 In LOAD, digest_in_valid=1 SHALL snapshot digest_in and set an internal captured flag; a later valid pulse in LOAD replaces the snapshot.
REQ-022 LOAD SHALL go to COMPARE on the first edge at which words_loaded is all ones and captured=1.
REQ-023 COMPARE SHALL hold busy=1 and compare exactly one word per cycle, index 0 up to DIGEST_WORDS-1, ORing the XOR differences into one accumulator.
REQ-024 COMPARE SHALL NOT exit early on a mismatch, so the compare is constant-time.
REQ-025 After the last word, the FSM SHALL enter RESULT with done=1 and with match=1 if the accumulator is zero, otherwise mismatch=1.
REQ-026 done SHALL rise exactly DIGEST_WORDS+2 cycles after the edge that registered the last outstanding item, whether that item was a word write or a digest capture.
REQ-027 RESULT SHALL hold done, match and mismatch stable until clear or rst.
REQ-028 clear=1 in LOAD, COMPARE or RESULT SHALL, on the next edge, enter LOAD and zero words_loaded, captured, busy, done, match and mismatch.
REQ-029 clear SHALL take priority over a we or digest_in_valid in the same cycle, so that write or capture is dropped.
REQ-030 match and mismatch SHALL never both be 1 at the same time.

Reset
REQ-031 On rst=1, the block SHALL enter LOAD and zero every output, the bitmap, the captured flag, the accumulator, the fail counter and all stored words.
REQ-032 rst SHALL override clear, we and digest_in_valid in any state, including the middle of a compare and LOCKED.

Configuration
REQ-033 Macro SHA_CHECK_LOCKOUT_EN SHALL select whether the lockout feature is compiled in.
REQ-034 With SHA_CHECK_LOCKOUT_EN defined, an 8-bit fail counter SHALL increment on each entry to RESULT with mismatch=1.
REQ-035 With SHA_CHECK_LOCKOUT_EN defined, reaching MAX_FAILS SHALL enter LOCKED, with locked=1, done=1, mismatch=1 and match=0.
REQ-036 With SHA_CHECK_LOCKOUT_EN defined, LOCKED SHALL ignore clear, we and digest_in_valid, and only rst SHALL leave LOCKED.
REQ-037 With SHA_CHECK_LOCKOUT_EN defined, a match result SHALL NOT reset the fail counter.
REQ-038 Without SHA_CHECK_LOCKOUT_EN, there SHALL be no counter and no LOCKED state, and locked SHALL be tied to 0.

Verification
REQ-039 SHALL cover: write words 0..7 of 256'h4c4e49536c6e69734c4e49536c6e69734c4e49536c6e69734c4e49536c6e6973, then pulse valid with the same digest -> done rises 10 cycles after the capture edge, match=1.
REQ-040 SHALL cover: the same case with digest_in bit 0 flipped -> mismatch=1 and done at the same cycle as a match (constant time).
REQ-041 SHALL cover: valid pulse first, then words written in order 7..0 with word 3 written twice (last write correct) -> match=1 and words_loaded=8'hFF.
REQ-042 SHALL cover: a write to address 5 with DIGEST_WORDS=5, and clear asserted together with we in COMPARE -> write ignored, FSM in LOAD and words_loaded=0 on the next edge.
REQ-043 SHALL cover: rst asserted at the 3rd compare cycle -> all outputs 0 on the next edge, and a following full load produces a correct result.
REQ-044 SHALL cover, with SHA_CHECK_LOCKOUT_EN defined and MAX_FAILS=3: three mismatches -> locked=1 and clear ignored; rst -> locked=0; without the macro, locked stays 0.
